// File: rtl/display_scan.sv
// Four-digit multiplexed 7-segment front end: sequential BCD conversion,
// blanking/sign/decimal-point formatting and a free-running digit scan.
module display_scan #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [13:0] value,
    input  logic        dp_en,
    input  logic [1:0]  dp_pos,
    input  logic        load,
    output logic        busy,
    output logic [3:0]  num,
    output logic        decimal,
    output logic [3:0]  digit
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_e;

    state_e           state_q, state_d;
    logic [13:0]      mag_q, mag_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [3:0]       iter_q, iter_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             cap_en_q, cap_en_d;
    logic [1:0]       cap_pos_q, cap_pos_d;
    logic [3:0][3:0]  disp_q, disp_d;
    logic             sdp_en_q, sdp_en_d;
    logic [1:0]       sdp_pos_q, sdp_pos_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       digit_q, digit_d;
    logic [3:0]       num_q, num_d;
    logic             dec_q, dec_d;

    logic [13:0]      neg_mag;
    logic             in_pos, in_neg;
    logic [15:0]      adj;
    logic [3:0][3:0]  fmt;
    logic [1:0]       msd, keep;

    // 14-bit codes 0..9999 are positive, codes of -999..-1 are negative,
    // every other code (10000..15384) is out of range.
    assign neg_mag = ~value + 14'd1;
    assign in_pos  = value <= 14'd9999;
    assign in_neg  = value >= 14'd15385;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        msd = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0)
                msd = 2'(i);
        end
        keep = msd;
        if (cap_en_q && cap_pos_q > msd)
            keep = cap_pos_q;
        for (int i = 0; i < 4; i++)
            fmt[i] = (2'(i) <= keep) ? bcd_q[4*i +: 4] : 4'hF;
        if (neg_q && keep != 2'd3)
            fmt[keep + 2'd1] = 4'hA;
        if (ovf_q)
            fmt = {4{4'hA}};
    end

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        bcd_d     = bcd_q;
        iter_d    = iter_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        cap_en_d  = cap_en_q;
        cap_pos_d = cap_pos_q;
        disp_d    = disp_q;
        sdp_en_d  = sdp_en_q;
        sdp_pos_d = sdp_pos_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d   = CONVERT;
                    mag_d     = in_neg ? neg_mag : value;
                    bcd_d     = '0;
                    iter_d    = '0;
                    neg_d     = in_neg;
                    ovf_d     = !(in_pos || in_neg);
                    cap_en_d  = dp_en;
                    cap_pos_d = dp_pos;
                end
            end
            CONVERT: begin
                bcd_d  = {adj[14:0], mag_q[13]};
                mag_d  = {mag_q[12:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd13)
                    state_d = COMMIT;
            end
            COMMIT: begin
                disp_d    = fmt;
                sdp_en_d  = cap_en_q && !ovf_q;
                sdp_pos_d = cap_pos_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pre_d = pre_q + PW'(1);
        idx_d = idx_q;
        if (pre_q == PRE_MAX) begin
            pre_d = '0;
            idx_d = idx_q + 2'd1;
        end
        digit_d = ~(4'b0001 << idx_d);
        num_d   = disp_q[idx_d];
        dec_d   = sdp_en_q && (sdp_pos_q == idx_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mag_q     <= '0;
            bcd_q     <= '0;
            iter_q    <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            cap_en_q  <= 1'b0;
            cap_pos_q <= '0;
            disp_q    <= {4{4'hF}};
            sdp_en_q  <= 1'b0;
            sdp_pos_q <= '0;
            pre_q     <= '0;
            idx_q     <= '0;
            digit_q   <= 4'b1110;
            num_q     <= 4'hF;
            dec_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            bcd_q     <= bcd_d;
            iter_q    <= iter_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            cap_en_q  <= cap_en_d;
            cap_pos_q <= cap_pos_d;
            disp_q    <= disp_d;
            sdp_en_q  <= sdp_en_d;
            sdp_pos_q <= sdp_pos_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            digit_q   <= digit_d;
            num_q     <= num_d;
            dec_q     <= dec_d;
        end
    end

    assign busy    = state_q != IDLE;
    assign num     = num_q;
    assign decimal = dec_q;
    assign digit   = digit_q;

endmodule

// File: tb/tb_display_scan.sv
// Randomized bench for display_scan against a decimal-arithmetic
// model of the formatted display and a cycle-counted scan model.
module tb_display_scan;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [13:0] value;
    logic        dp_en;
    logic [1:0]  dp_pos;
    logic        load;
    logic        busy;
    logic [3:0]  num;
    logic        decimal;
    logic [3:0]  digit;

    int checks   = 0;
    int failures = 0;
    int n        = 0;
    int exp_d[4];
    int exp_de;
    int exp_dp;

    display_scan #(.REFRESH_DIV(4)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .value  (value),
        .dp_en  (dp_en),
        .dp_pos (dp_pos),
        .load   (load),
        .busy   (busy),
        .num    (num),
        .decimal(decimal),
        .digit  (digit)
    );

    always #5 clk = ~clk;

    // posedges since reset release; the scan index follows n/4
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) n <= 0;
        else n <= n + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_blank();
        exp_d  = '{15, 15, 15, 15};
        exp_de = 0;
        exp_dp = 0;
    endtask

    task automatic model_load(input int s, input bit de, input int dpp);
        int mag, msd, keep;
        int bcd[4];
        exp_dp = dpp;
        if (s > 9999 || s < -999) begin
            exp_d  = '{10, 10, 10, 10};
            exp_de = 0;
            return;
        end
        mag = (s < 0) ? -s : s;
        for (int i = 0; i < 4; i++) bcd[i] = (mag / (10 ** i)) % 10;
        msd = 0;
        for (int i = 0; i < 4; i++) if (bcd[i] != 0) msd = i;
        keep = (de && dpp > msd) ? dpp : msd;
        for (int i = 0; i < 4; i++) exp_d[i] = (i <= keep) ? bcd[i] : 15;
        if (s < 0 && keep < 3) exp_d[keep + 1] = 10;
        exp_de = de;
    endtask

    task automatic chk_scan();
        int idx;
        for (int j = 0; j < 16; j++) begin
            idx = (n / 4) % 4;
            chk("digit", digit, 15 - (1 << idx));
            chk("num", num, exp_d[idx]);
            chk("decimal", decimal, (exp_de != 0 && exp_dp == idx) ? 1 : 0);
            @(negedge clk);
        end
    endtask

    task automatic do_load(input int s, input bit de, input int dpp, input bit ign);
        int cnt;
        value  = 14'(s);
        dp_en  = de;
        dp_pos = 2'(dpp);
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        model_load(s, de, dpp);
        cnt = 0;
        while (busy && cnt < 40) begin
            if (ign && cnt == 4) begin
                value = 14'd1234;
                dp_en = 1'b1;
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            cnt++;
        end
        load = 1'b0;
        chk("busy_len", cnt, 15);
        @(negedge clk);
        chk_scan();
    endtask

    initial begin
        int s, cat;
        bit de;
        int dpp;
        reset_n = 1'b0;
        value   = '0;
        dp_en   = 1'b0;
        dp_pos  = '0;
        load    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_digit", digit, 14);
        chk("rst_num", num, 15);
        chk("rst_decimal", decimal, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        @(negedge clk);
        model_blank();
        chk_scan();

        do_load(1234, 0, 0, 0);
        do_load(7, 0, 0, 0);
        do_load(-45, 0, 0, 0);
        do_load(5, 1, 2, 0);
        do_load(0, 0, 0, 0);
        do_load(10000, 1, 1, 0);
        do_load(-1000, 0, 0, 1);

        // reset lands in the 7th conversion cycle
        value  = 14'd9999;
        dp_en  = 1'b0;
        dp_pos = '0;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_digit", digit, 14);
        chk("mid_num", num, 15);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        model_blank();
        chk_scan();
        do_load(9999, 0, 0, 0);

        for (int k = 0; k < 16; k++) begin
            cat = int'($urandom_range(0, 3));
            case (cat)
                0: s = int'($urandom_range(0, 9999));
                1: s = -int'($urandom_range(1, 999));
                2: s = int'($urandom_range(0, 99));
                default: s = ($urandom_range(0, 1) != 0) ?
                             int'($urandom_range(10000, 15384)) :
                             -int'($urandom_range(1000, 6384));
            endcase
            de  = 1'($urandom_range(0, 1));
            dpp = int'($urandom_range(0, 3));
            do_load(s, de, dpp, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
